dma_arbiter: RTL

Two-requester arbiter sharing the single openMSP430 DMA master port. It sits between two DMA engines, such as a DMA controller channel and a debug/attestation copier, and the core's `dma_*` interface. It grants one requester at a time using round-robin, optional priority override and bounded locked bursts. It muxes the owner's address, data and write-enable onto the core port and routes `dma_ready`, `dma_resp` and read data back to the owner only.

---
 rtl/dma_arb_pkg.sv | 19 +
 rtl/dma_arb_pick.sv | 37 +++
 rtl/dma_arbiter.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/dma_arb_pkg.sv
// Shared types and constants for the two-requester DMA port arbiter.
package dma_arb_pkg;

    localparam int NREQ    = 2;
    localparam int BURST_W = 8;

    localparam logic [1:0] WE_READ = 2'b00;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_GRANT  = 2'd1;
    localparam logic [1:0] S_RDWAIT = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = S_IDLE,
        ST_GRANT  = S_GRANT,
        ST_RDWAIT = S_RDWAIT
    } arb_state_t;

endpackage

// File: rtl/dma_arb_pick.sv
// Combinational winner select: round-robin on rr_last_i, priority override when DMA_ARB_PRIORITY_EN.
// Zero latency; no backpressure (pure function of the current requests).
module dma_arb_pick
    import dma_arb_pkg::*;
(
    input  logic [NREQ-1:0] req_en_i,
    input  logic [NREQ-1:0] req_priority_i,
    input  logic            rr_last_i,
    output logic            winner_o,
    output logic            any_o
);

`ifndef DMA_ARB_PRIORITY_EN
    logic unused_priority;
    assign unused_priority = ^req_priority_i;
`endif

    always_comb begin
        winner_o = 1'b0;
        any_o    = |req_en_i;
        unique case (req_en_i)
            2'b01: winner_o = 1'b0;
            2'b10: winner_o = 1'b1;
            2'b11: begin
                winner_o = ~rr_last_i;
`ifdef DMA_ARB_PRIORITY_EN
                // A lone high-priority requester wins; equal priority stays fair.
                if (req_priority_i[0] != req_priority_i[1]) begin
                    winner_o = req_priority_i[1];
                end
`endif
            end
            default: winner_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/dma_arbiter.sv
// Two-requester owner of the openMSP430 DMA port (priority override with DMA_ARB_PRIORITY_EN).
// req_en to dma_en 1 cycle; req_ready/req_resp pass dma_ready/dma_resp to the owner only.
module dma_arbiter
    import dma_arb_pkg::*;
#(
    parameter int DATA      = 16,
    parameter int ADD       = 15,
    parameter int MAX_BURST = 8
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [1:0]        req_en_i,
    input  logic [3:0]        req_we_i,
    input  logic [2*ADD-1:0]  req_addr_i,
    input  logic [2*DATA-1:0] req_din_i,
    input  logic [1:0]        req_priority_i,
    input  logic [1:0]        req_lock_i,
    output logic [1:0]        req_ready_o,
    output logic [1:0]        req_resp_o,
    output logic [DATA-1:0]   req_dout_o,
    output logic [1:0]        grant_o,
    output logic              dma_en_o,
    output logic [1:0]        dma_we_o,
    output logic [ADD-1:0]    dma_addr_o,
    output logic [DATA-1:0]   dma_din_o,
    output logic              dma_priority_o,
    input  logic              dma_ready_i,
    input  logic              dma_resp_i,
    input  logic [DATA-1:0]   dma_dout_i
);

    localparam logic [BURST_W:0] MAX_B = MAX_BURST[BURST_W:0];

    arb_state_t           state_q, state_d;
    logic                 owner_q, owner_d;
    logic                 rr_last_q, rr_last_d;
    logic [BURST_W-1:0]   burst_cnt_q, burst_cnt_d;

    logic                 pick_winner, pick_any;
    logic                 own_en, own_lock, accept;
    logic [1:0]           own_we;
    logic [ADD-1:0]       own_addr;
    logic [DATA-1:0]      own_din;
    logic [BURST_W:0]     cnt_inc;

    dma_arb_pick u_pick (
        .req_en_i       (req_en_i),
        .req_priority_i (req_priority_i),
        .rr_last_i      (rr_last_q),
        .winner_o       (pick_winner),
        .any_o          (pick_any)
    );

    assign own_en   = owner_q ? req_en_i[1]   : req_en_i[0];
    assign own_lock = owner_q ? req_lock_i[1] : req_lock_i[0];
    assign own_we   = owner_q ? req_we_i[3:2] : req_we_i[1:0];
    assign own_addr = owner_q ? req_addr_i[2*ADD-1:ADD]   : req_addr_i[ADD-1:0];
    assign own_din  = owner_q ? req_din_i[2*DATA-1:DATA]  : req_din_i[DATA-1:0];
    assign accept   = (state_q == ST_GRANT) && own_en && dma_ready_i;
    assign cnt_inc  = {1'b0, burst_cnt_q} + {{BURST_W{1'b0}}, 1'b1};

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            owner_q     <= 1'b0;
            rr_last_q   <= 1'b1;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_last_q   <= rr_last_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_last_d   = rr_last_q;
        burst_cnt_d = burst_cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    owner_d     = pick_winner;
                    burst_cnt_d = '0;
                    state_d     = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (accept) begin
                    burst_cnt_d = cnt_inc[BURST_W-1:0];
                    if (own_we == WE_READ) begin
                        state_d = ST_RDWAIT;
                    end else if (!(own_lock && (cnt_inc < MAX_B))) begin
                        state_d   = ST_IDLE;
                        rr_last_d = owner_q;
                    end
                end else if (!own_en) begin
                    state_d   = ST_IDLE;
                    rr_last_d = owner_q;
                end
            end
            ST_RDWAIT: begin
                // Burst count was already bumped on the read accept.
                if (own_lock && ({1'b0, burst_cnt_q} < MAX_B) && own_en) begin
                    state_d = ST_GRANT;
                end else begin
                    state_d   = ST_IDLE;
                    rr_last_d = owner_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        grant_o        = 2'b00;
        dma_en_o       = 1'b0;
        dma_we_o       = 2'b00;
        dma_addr_o     = '0;
        dma_din_o      = '0;
        dma_priority_o = 1'b0;
        req_ready_o    = 2'b00;
        req_resp_o     = 2'b00;
        req_dout_o     = '0;
        if (state_q != ST_IDLE) begin
            grant_o[owner_q]    = 1'b1;
            dma_we_o            = own_we;
            dma_addr_o          = own_addr;
            dma_din_o           = own_din;
            req_resp_o[owner_q] = dma_resp_i;
`ifdef DMA_ARB_PRIORITY_EN
            dma_priority_o      = owner_q ? req_priority_i[1] : req_priority_i[0];
`endif
        end
        if (state_q == ST_GRANT) begin
            dma_en_o             = own_en;
            req_ready_o[owner_q] = dma_ready_i & own_en;
        end
        if (state_q == ST_RDWAIT) begin
            req_dout_o = dma_dout_i;
        end
    end

endmodule
